divmod_seq: RTL and testbench

Parametrised sequential integer divider producing quotient and remainder for unsigned or signed (two's-complement) operands, selected per operation. It replaces the fixed-width unsigned `go`/`ready` divider with valid/ready handshakes on both sides, fixed data-independent latency, and explicit divide-by-zero and signed-overflow reporting. It sits between the prime-search control FSM and the candidate/divisor registers and is shared by any datapath needing `a / b` and `a % b`.

---
 rtl/divmod_seq_if.sv | 26 ++
 rtl/divmod_seq.sv | 147 ++++++++++++++
 tb/tb_divmod_seq.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/divmod_seq_if.sv
// Valid/ready operand and result channels of the sequential divider.
interface divmod_seq_if #(
   parameter int unsigned WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             sgn;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] quo;
   logic [WIDTH-1:0] rem;
   logic             err_dz;
   logic             err_ovf;

   modport master (
      output in_valid, a, b, sgn, out_ready,
      input  in_ready, out_valid, quo, rem, err_dz, err_ovf
   );

   modport slave (
      input  in_valid, a, b, sgn, out_ready,
      output in_ready, out_valid, quo, rem, err_dz, err_ovf
   );
endinterface

// File: rtl/divmod_seq.sv
// Restoring radix-2 signed/unsigned divider with fixed latency and
// divide-by-zero / signed-overflow short-cuts.
module divmod_seq #(
   parameter int unsigned WIDTH = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   divmod_seq_if.slave bus
);
   localparam int unsigned CW = $clog2(WIDTH);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_FIX  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   localparam logic [WIDTH-1:0] MIN_V  = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH-1:0] ONES_V = '1;

   logic [1:0]       state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] dvd_q, dvd_d;
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic [WIDTH-1:0] prem_q, prem_d;
   logic             qneg_q, qneg_d;
   logic             rneg_q, rneg_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic             err_dz_q, err_dz_d;
   logic             err_ovf_q, err_ovf_d;
   logic             in_ready_q, in_ready_d;
   logic             out_valid_q, out_valid_d;

   logic [WIDTH-1:0] a_abs_c, b_abs_c;
   logic [WIDTH:0]   shift_c, trial_c;

   // Next-state and datapath; dvd_q shifts out dividend bits and in quotient bits.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      dvd_d     = dvd_q;
      dvs_d     = dvs_q;
      prem_d    = prem_q;
      qneg_d    = qneg_q;
      rneg_d    = rneg_q;
      quo_d     = quo_q;
      rem_d     = rem_q;
      err_dz_d  = err_dz_q;
      err_ovf_d = err_ovf_q;

      a_abs_c = (bus.sgn && bus.a[WIDTH-1]) ? -bus.a : bus.a;
      b_abs_c = (bus.sgn && bus.b[WIDTH-1]) ? -bus.b : bus.b;
      shift_c = {prem_q, dvd_q[WIDTH-1]};
      trial_c = shift_c - {1'b0, dvs_q};

      case (state_q)
         S_IDLE: begin
            if (bus.in_valid) begin
               if (bus.b == '0) begin
                  state_d   = S_DONE;
                  quo_d     = ONES_V;
                  rem_d     = bus.a;
                  err_dz_d  = 1'b1;
                  err_ovf_d = 1'b0;
               end else if (bus.sgn && bus.a == MIN_V && bus.b == ONES_V) begin
                  state_d   = S_DONE;
                  quo_d     = bus.a;
                  rem_d     = '0;
                  err_dz_d  = 1'b0;
                  err_ovf_d = 1'b1;
               end else begin
                  state_d   = S_CALC;
                  dvd_d     = a_abs_c;
                  dvs_d     = b_abs_c;
                  qneg_d    = bus.sgn & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                  rneg_d    = bus.sgn & bus.a[WIDTH-1];
                  cnt_d     = '0;
                  prem_d    = '0;
                  err_dz_d  = 1'b0;
                  err_ovf_d = 1'b0;
               end
            end
         end
         S_CALC: begin
            // Borrow out of the trial subtraction means the divisor did not fit.
            prem_d = trial_c[WIDTH] ? shift_c[WIDTH-1:0] : trial_c[WIDTH-1:0];
            dvd_d  = {dvd_q[WIDTH-2:0], ~trial_c[WIDTH]};
            cnt_d  = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
               state_d = S_FIX;
            end
         end
         S_FIX: begin
            quo_d   = qneg_q ? -dvd_q : dvd_q;
            rem_d   = rneg_q ? -prem_q : prem_q;
            state_d = S_DONE;
         end
         default: begin
            if (bus.out_ready) begin
               state_d = S_IDLE;
            end
         end
      endcase

      in_ready_d  = (state_d == S_IDLE);
      out_valid_d = (state_d == S_DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         dvd_q       <= '0;
         dvs_q       <= '0;
         prem_q      <= '0;
         qneg_q      <= 1'b0;
         rneg_q      <= 1'b0;
         quo_q       <= '0;
         rem_q       <= '0;
         err_dz_q    <= 1'b0;
         err_ovf_q   <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         dvd_q       <= dvd_d;
         dvs_q       <= dvs_d;
         prem_q      <= prem_d;
         qneg_q      <= qneg_d;
         rneg_q      <= rneg_d;
         quo_q       <= quo_d;
         rem_q       <= rem_d;
         err_dz_q    <= err_dz_d;
         err_ovf_q   <= err_ovf_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.quo       = quo_q;
   assign bus.rem       = rem_q;
   assign bus.err_dz    = err_dz_q;
   assign bus.err_ovf   = err_ovf_q;
endmodule

// File: tb/tb_divmod_seq.sv
// Scoreboarded bench for divmod_seq at WIDTH 16 (directed) and 8/32 (random).
module tb_divmod_seq;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   divmod_seq_if #(.WIDTH(16)) b16 ();
   divmod_seq_if #(.WIDTH(8))  b8  ();
   divmod_seq_if #(.WIDTH(32)) b32 ();

   divmod_seq #(.WIDTH(16)) u16 (.clk(clk), .rst_n(rst_n), .bus(b16));
   divmod_seq #(.WIDTH(8))  u8  (.clk(clk), .rst_n(rst_n), .bus(b8));
   divmod_seq #(.WIDTH(32)) u32 (.clk(clk), .rst_n(rst_n), .bus(b32));

   typedef struct packed {
      logic [63:0] q;
      logic [63:0] r;
      logic        dz;
      logic        ovf;
   } exp_t;

   typedef struct packed {
      logic        ir;
      logic        ov;
      logic [63:0] q;
      logic [63:0] r;
      logic        dz;
      logic        ovf;
   } obs_t;

   exp_t sb[$];
   exp_t last_e;
   int   n_vec = 0;
   int   n_err = 0;

   function automatic int wid(input int sel);
      case (sel)
         0:       return 16;
         1:       return 8;
         default: return 32;
      endcase
   endfunction

   function automatic exp_t mk(input logic [63:0] q, input logic [63:0] r,
                               input logic dz, input logic ovf);
      exp_t e;
      e.q = q; e.r = r; e.dz = dz; e.ovf = ovf;
      return e;
   endfunction

   // Reference: language division truncates toward zero, matching C semantics.
   function automatic exp_t model(input int w, input logic [63:0] ai,
                                  input logic [63:0] bi, input logic s);
      logic [63:0] m, a, b;
      longint      sa, sbv, sq, sr;
      exp_t        e;
      m = (64'd1 << w) - 64'd1;
      a = ai & m;
      b = bi & m;
      e = mk(64'd0, 64'd0, 1'b0, 1'b0);
      if (b == 64'd0) begin
         e = mk(m, a, 1'b1, 1'b0);
      end else if (!s) begin
         e = mk(a / b, a % b, 1'b0, 1'b0);
      end else if (a == (64'd1 << (w - 1)) && b == m) begin
         e = mk(a, 64'd0, 1'b0, 1'b1);
      end else begin
         sa  = a << (64 - w);
         sa  = sa >>> (64 - w);
         sbv = b << (64 - w);
         sbv = sbv >>> (64 - w);
         sq  = sa / sbv;
         sr  = sa % sbv;
         e = mk(64'(sq) & m, 64'(sr) & m, 1'b0, 1'b0);
      end
      return e;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_in(input int sel, input logic v, input logic [63:0] a,
                         input logic [63:0] b, input logic s);
      case (sel)
         0: begin b16.in_valid = v; b16.a = a[15:0]; b16.b = b[15:0]; b16.sgn = s; end
         1: begin b8.in_valid  = v; b8.a  = a[7:0];  b8.b  = b[7:0];  b8.sgn  = s; end
         default: begin b32.in_valid = v; b32.a = a[31:0]; b32.b = b[31:0]; b32.sgn = s; end
      endcase
   endtask

   task automatic set_ordy(input int sel, input logic v);
      case (sel)
         0:       b16.out_ready = v;
         1:       b8.out_ready  = v;
         default: b32.out_ready = v;
      endcase
   endtask

   function automatic obs_t get(input int sel);
      obs_t o;
      case (sel)
         0: begin
            o.ir = b16.in_ready; o.ov = b16.out_valid; o.q = 64'(b16.quo);
            o.r = 64'(b16.rem); o.dz = b16.err_dz; o.ovf = b16.err_ovf;
         end
         1: begin
            o.ir = b8.in_ready; o.ov = b8.out_valid; o.q = 64'(b8.quo);
            o.r = 64'(b8.rem); o.dz = b8.err_dz; o.ovf = b8.err_ovf;
         end
         default: begin
            o.ir = b32.in_ready; o.ov = b32.out_valid; o.q = 64'(b32.quo);
            o.r = 64'(b32.rem); o.dz = b32.err_dz; o.ovf = b32.err_ovf;
         end
      endcase
      return o;
   endfunction

   // Present operands, wait for acceptance, push the expectation, then scramble inputs.
   task automatic start(input int sel, input logic [63:0] a, input logic [63:0] b,
                        input logic s, input exp_t e);
      int   t = 0;
      obs_t o;
      @(negedge clk);
      set_in(sel, 1'b1, a, b, s);
      o = get(sel);
      while (!o.ir && t < 100) begin
         @(negedge clk);
         t++;
         o = get(sel);
      end
      chk("in_ready", 64'(o.ir), 64'd1);
      @(posedge clk);
      sb.push_back(e);
      #1 set_in(sel, 1'b0, ~a, ~b, ~s);
   endtask

   // Count cycles to out_valid and compare against the oldest expectation.
   task automatic wait_out(input int sel);
      int   n = 0;
      obs_t o;
      do begin
         @(posedge clk);
         @(negedge clk);
         n++;
         o = get(sel);
      end while (!o.ov && n < 200);
      chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
      last_e = (sb.size() != 0) ? sb.pop_front() : mk(64'd0, 64'd0, 1'b0, 1'b0);
      chk("latency", 64'(n), 64'((last_e.dz | last_e.ovf) ? 1 : wid(sel) + 1));
      chk("quo", o.q, last_e.q);
      chk("rem", o.r, last_e.r);
      chk("err_dz", 64'(o.dz), 64'(last_e.dz));
      chk("err_ovf", 64'(o.ovf), 64'(last_e.ovf));
   endtask

   task automatic handshake(input int sel);
      obs_t o;
      set_ordy(sel, 1'b1);
      @(posedge clk);
      #1 set_ordy(sel, 1'b0);
      @(negedge clk);
      o = get(sel);
      chk("idle_in_ready", 64'(o.ir), 64'd1);
      chk("idle_out_valid", 64'(o.ov), 64'd0);
   endtask

   task automatic op(input int sel, input logic [63:0] a, input logic [63:0] b,
                     input logic s, input exp_t e);
      start(sel, a, b, s, e);
      wait_out(sel);
      handshake(sel);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      obs_t        o;
      logic [63:0] ra, rb, m;
      logic        rs;
      int          w;

      for (int s = 0; s < 3; s++) begin
         set_in(s, 1'b0, 64'd0, 64'd0, 1'b0);
         set_ordy(s, 1'b0);
      end

      // In-reset: in_valid must be ignored and outputs sit at reset values.
      set_in(0, 1'b1, 64'h5, 64'h1, 1'b0);
      #23;
      o = get(0);
      chk("rst_in_ready", 64'(o.ir), 64'd1);
      chk("rst_out_valid", 64'(o.ov), 64'd0);
      chk("rst_quo", o.q, 64'd0);
      chk("rst_rem", o.r, 64'd0);
      chk("rst_err_dz", 64'(o.dz), 64'd0);
      chk("rst_err_ovf", 64'(o.ovf), 64'd0);
      set_in(0, 1'b0, 64'd0, 64'd0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      o = get(0);
      chk("post_rst_out_valid", 64'(o.ov), 64'd0);

      op(0, 64'hFFF9, 64'h0002, 1'b0, mk(64'h7FFC, 64'h0001, 1'b0, 1'b0));
      op(0, 64'hFFF9, 64'h0002, 1'b1, mk(64'hFFFD, 64'hFFFF, 1'b0, 1'b0));
      op(0, 64'h0007, 64'hFFFE, 1'b1, mk(64'hFFFD, 64'h0001, 1'b0, 1'b0));
      op(0, 64'h1234, 64'h0000, 1'b0, mk(64'hFFFF, 64'h1234, 1'b1, 1'b0));
      op(0, 64'h1234, 64'h0000, 1'b1, mk(64'hFFFF, 64'h1234, 1'b1, 1'b0));
      op(0, 64'h8000, 64'hFFFF, 1'b1, mk(64'h8000, 64'h0000, 1'b0, 1'b1));
      op(0, 64'h8000, 64'hFFFF, 1'b0, mk(64'h0000, 64'h8000, 1'b0, 1'b0));
      op(0, 64'h8000, 64'h0001, 1'b1, mk(64'h8000, 64'h0000, 1'b0, 1'b0));
      op(0, 64'h8000, 64'h0002, 1'b1, mk(64'hC000, 64'h0000, 1'b0, 1'b0));
      op(0, 64'hFFFF, 64'hFFFF, 1'b0, mk(64'h0001, 64'h0000, 1'b0, 1'b0));

      // Backpressure: results hold, new operands are not taken.
      start(0, 64'd1000, 64'd3, 1'b0, mk(64'd333, 64'd1, 1'b0, 1'b0));
      wait_out(0);
      for (int i = 0; i < 10; i++) begin
         set_in(0, 1'b1, 64'd9 + 64'(i), 64'd9, 1'b1);
         @(negedge clk);
         o = get(0);
         chk("bp_quo", o.q, last_e.q);
         chk("bp_rem", o.r, last_e.r);
         chk("bp_in_ready", 64'(o.ir), 64'd0);
         chk("bp_out_valid", 64'(o.ov), 64'd1);
      end
      set_in(0, 1'b0, 64'd0, 64'd0, 1'b0);
      handshake(0);
      op(0, 64'd50, 64'd7, 1'b0, mk(64'd7, 64'd1, 1'b0, 1'b0));

      // Reset during CALC aborts the operation.
      start(0, 64'd5000, 64'd3, 1'b0, mk(64'd1666, 64'd2, 1'b0, 1'b0));
      repeat (5) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      o = get(0);
      chk("abort_in_ready", 64'(o.ir), 64'd1);
      chk("abort_out_valid", 64'(o.ov), 64'd0);
      chk("abort_quo", o.q, 64'd0);
      chk("abort_rem", o.r, 64'd0);
      void'(sb.pop_back());
      @(negedge clk);
      rst_n = 1'b1;
      op(0, 64'd100, 64'd7, 1'b0, mk(64'd14, 64'd2, 1'b0, 1'b0));

      // Random vectors at WIDTH 8 and 32, with forced corner operands.
      for (int sel = 1; sel < 3; sel++) begin
         w = wid(sel);
         m = (64'd1 << w) - 64'd1;
         for (int i = 0; i < 400; i++) begin
            ra = {32'($urandom), 32'($urandom)} & m;
            rb = {32'($urandom), 32'($urandom)} & m;
            rs = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 15))
               0:       rb = 64'd0;
               1:       begin ra = 64'd1 << (w - 1); rb = m; end
               2:       rb = 64'($urandom_range(1, 5));
               3:       rb = m;
               default: ;
            endcase
            op(sel, ra, rb, rs, model(w, ra, rb, rs));
         end
      end

      chk("sb_empty", 64'(sb.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
